// File: rtl/sram_requester.sv
// -----------------------------------------------------------------------------
// sram_requester
//
// Initiator side of the 16-bit dual-bank SRAM macro interface. Core requests
// arrive on a valid/ready port and are turned into one macro operation per
// cycle. Read data and write acknowledgements come back in request order at a
// fixed latency. The macro has no write mask, so byte-masked writes are done
// as read-modify-write (RMW): read the word, merge, write it back.
//
// Latency (request accepted in cycle T):
//   read / full write / empty-mask write : resp_valid in T+2
//   partial write (RMW)                  : resp_valid in T+4, req_ready low
//                                          in T+1 and T+2
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   req_valid      request present
//   req_ready      request accepted when req_valid && req_ready
//   req_we         1 = write, 0 = read
//   req_addr       word address
//   req_wdata      write data
//   req_bmask      byte enables for writes (bit0 = [7:0], bit1 = [15:8])
//   resp_valid     one-cycle pulse per accepted request
//   resp_rdata     read data; 0 for write acknowledgements
//   mem_cs         macro chip select
//   mem_we         macro write enable
//   mem_wr_addr    macro write address
//   mem_rd_addr    macro read address
//   mem_wdata      macro write data
//   mem_rdata      macro read data, valid the cycle after a read issue and
//                  held while mem_cs is low
// -----------------------------------------------------------------------------
module sram_requester #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_bmask,

    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,

    output logic                mem_cs,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BM_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_WAIT = 2'd1,   // RMW read in flight, merge with mem_rdata
        RMW_WR   = 2'd2    // write the merged word back
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;      // last accepted address
    logic [DATA_W-1:0]   wdata_q,      wdata_d;     // write data, then merged word
    logic [BM_W-1:0]     bmask_q,      bmask_d;     // byte mask of pending RMW

    // Response pipeline: stage 1 is loaded when the final memory op of a
    // request issues; stage 2 is the visible response. Read data is captured
    // on the stage 1 -> stage 2 move, the cycle the macro presents it.
    logic                p1_valid_q,   p1_valid_d;
    logic                p1_read_q,    p1_read_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic accept;
    logic mask_full;
    logic mask_none;

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign mask_full = &req_bmask;
    assign mask_none = ~|req_bmask;

    // Merge for the RMW: selected bytes from the latched write data, the rest
    // from the word the macro returned for the RMW read.
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = mem_rdata;
        for (int b = 0; b < BM_W; b++) begin
            if (bmask_q[b]) begin
                merged[b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and memory-pin logic
    // -------------------------------------------------------------------------
    logic load_resp;
    logic load_is_read;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise a latch would be inferred.
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        bmask_d      = bmask_q;
        load_resp    = 1'b0;
        load_is_read = 1'b0;

        // With no op issued the address/data pins just hold the last values.
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_wr_addr  = addr_q;
        mem_rd_addr  = addr_q;
        mem_wdata    = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Pins follow the request combinationally in the accept cycle.
                    addr_d      = req_addr;
                    mem_wr_addr = req_addr;
                    mem_rd_addr = req_addr;
                    if (!req_we) begin
                        mem_cs       = 1'b1;
                        load_resp    = 1'b1;
                        load_is_read = 1'b1;
                    end else if (mask_full) begin
                        mem_cs    = 1'b1;
                        mem_we    = 1'b1;
                        mem_wdata = req_wdata;
                        wdata_d   = req_wdata;
                        load_resp = 1'b1;
                    end else if (mask_none) begin
                        // Nothing to write: acknowledge without touching the macro.
                        load_resp = 1'b1;
                    end else begin
                        // Partial write: issue the read half of the RMW.
                        mem_cs  = 1'b1;
                        wdata_d = req_wdata;
                        bmask_d = req_bmask;
                        state_d = RMW_WAIT;
                    end
                end
            end

            RMW_WAIT: begin
                // mem_rdata holds the old word this cycle; keep the merge in
                // wdata_q so the write cycle drives it straight from a flop.
                wdata_d = merged;
                state_d = RMW_WR;
            end

            RMW_WR: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                load_resp = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The pins are quiet and zero in any cycle with reset asserted, even
        // before the flops have taken their reset values.
        if (!rst_n) begin
            mem_cs      = 1'b0;
            mem_we      = 1'b0;
            mem_wr_addr = '0;
            mem_rd_addr = '0;
            mem_wdata   = '0;
        end
    end

    // Response pipeline next values.
    always_comb begin
        p1_valid_d   = load_resp;
        p1_read_d    = load_is_read;
        resp_valid_d = p1_valid_q;
        resp_rdata_d = (p1_valid_q && p1_read_q) ? mem_rdata : '0;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // rather than in the sensitivity list. Sequential state always uses
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            bmask_q      <= '0;
            p1_valid_q   <= 1'b0;
            p1_read_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            bmask_q      <= bmask_d;
            p1_valid_q   <= p1_valid_d;
            p1_read_q    <= p1_read_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_sram_requester.sv
// -----------------------------------------------------------------------------
// tb_sram_requester
//
// Directed bench for sram_requester. A small behavioural SRAM macro sits on
// the mem_* pins (write commits at the clock edge, read data registered one
// cycle later and held while cs is low) and has a backdoor port for preloads.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Each task scripts one scenario cycle by cycle.
// -----------------------------------------------------------------------------
module tb_sram_requester;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [1:0]          req_bmask;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                mem_cs;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    int n_assert;
    int n_fail;

    sram_requester #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_bmask   (req_bmask),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_wr_addr (mem_wr_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SRAM macro model ----------------
    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en)
            sram[pre_addr] <= pre_data;
        else if (mem_cs && mem_we)
            sram[mem_wr_addr] <= mem_wdata;
        if (mem_cs && !mem_we)
            mem_rdata <= sram[mem_rd_addr];
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [1:0] bm);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_bmask = bm;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 2'b00);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        tick();
        idle();
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 12'h005, 16'h0000, 2'b00);
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            n_assert++;
            if ({req_ready, mem_cs, mem_we, resp_valid} !== 4'b0000) begin
                $display("FAIL reset_ctrl c%0d: ready/cs/we/resp_valid=%b expected 0000",
                         c, {req_ready, mem_cs, mem_we, resp_valid});
                n_fail++;
            end
            n_assert++;
            if ({mem_rd_addr, mem_wr_addr, mem_wdata, resp_rdata} !== '0) begin
                $display("FAIL reset_bus c%0d: rd=%h wr=%h wd=%h rdata=%h expected all 0",
                         c, mem_rd_addr, mem_wr_addr, mem_wdata, resp_rdata);
                n_fail++;
            end
        end
        tick();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, resp_valid} !== 3'b100) begin
            $display("FAIL reset_release: ready/cs/resp_valid=%b expected 100",
                     {req_ready, mem_cs, resp_valid});
            n_fail++;
        end
    endtask

    task automatic test_write_read();
        tick();
        drive(1'b1, 1'b1, 12'h010, 16'h1234, 2'b11);
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we} !== 3'b111) begin
            $display("FAIL wr_issue: ready/cs/we=%b expected 111", {req_ready, mem_cs, mem_we});
            n_fail++;
        end
        n_assert++;
        if ({mem_wr_addr, mem_wdata} !== {12'h010, 16'h1234}) begin
            $display("FAIL wr_bus: addr=%h data=%h expected 010 1234", mem_wr_addr, mem_wdata);
            n_fail++;
        end

        tick();
        drive(1'b1, 1'b0, 12'h010, 16'h0000, 2'b00);
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, mem_rd_addr} !== {3'b110, 12'h010}) begin
            $display("FAIL rd_issue: ready/cs/we=%b addr=%h expected 110 010",
                     {req_ready, mem_cs, mem_we}, mem_rd_addr);
            n_fail++;
        end
        n_assert++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL wr_ack_early: resp_valid=%b expected 0", resp_valid);
            n_fail++;
        end

        tick();
        idle();
        @(negedge clk);
        n_assert++;
        if ({resp_valid, resp_rdata} !== {1'b1, 16'h0000}) begin
            $display("FAIL wr_ack: valid=%b rdata=%h expected 1 0000", resp_valid, resp_rdata);
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if ({resp_valid, resp_rdata} !== {1'b1, 16'h1234}) begin
            $display("FAIL raw_read: valid=%b rdata=%h expected 1 1234", resp_valid, resp_rdata);
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL wr_read_tail: resp_valid=%b expected 0", resp_valid);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_data;
        for (int i = 0; i < 4; i++) preload(ADDR_W'(i), 16'hA000 + DATA_W'(i));
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c < 4) drive(1'b1, 1'b0, ADDR_W'(c), 16'h0000, 2'b00);
            else       idle();
            @(negedge clk);
            if (c < 4) begin
                n_assert++;
                if ({req_ready, mem_cs, mem_we, mem_rd_addr} !== {3'b110, ADDR_W'(c)}) begin
                    $display("FAIL b2b_issue c%0d: ready/cs/we=%b addr=%h expected 110 %h",
                             c, {req_ready, mem_cs, mem_we}, mem_rd_addr, ADDR_W'(c));
                    n_fail++;
                end
            end
            n_assert++;
            if (c >= 2 && c <= 5) begin
                exp_data = 16'hA000 + DATA_W'(c - 2);
                if ({resp_valid, resp_rdata} !== {1'b1, exp_data}) begin
                    $display("FAIL b2b_resp c%0d: valid=%b rdata=%h expected 1 %h",
                             c, resp_valid, resp_rdata, exp_data);
                    n_fail++;
                end
            end else if (resp_valid !== 1'b0) begin
                $display("FAIL b2b_resp c%0d: valid=%b expected 0", c, resp_valid);
                n_fail++;
            end
        end
    endtask

    task automatic test_rmw(input logic [1:0] bm, input logic [DATA_W-1:0] wd,
                            input logic [DATA_W-1:0] merged);
        preload(12'h020, 16'hBEEF);

        tick();
        drive(1'b1, 1'b1, 12'h020, wd, bm);
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, mem_rd_addr} !== {3'b110, 12'h020}) begin
            $display("FAIL rmw_rd bm=%b: ready/cs/we=%b addr=%h expected 110 020",
                     bm, {req_ready, mem_cs, mem_we}, mem_rd_addr);
            n_fail++;
        end

        // A read waits behind the RMW and must stall until the write is out.
        tick();
        drive(1'b1, 1'b0, 12'h020, 16'h0000, 2'b00);
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, resp_valid} !== 4'b0000) begin
            $display("FAIL rmw_wait bm=%b: ready/cs/we/resp=%b expected 0000",
                     bm, {req_ready, mem_cs, mem_we, resp_valid});
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we} !== 3'b011) begin
            $display("FAIL rmw_wr bm=%b: ready/cs/we=%b expected 011",
                     bm, {req_ready, mem_cs, mem_we});
            n_fail++;
        end
        n_assert++;
        if ({mem_wr_addr, mem_wdata} !== {12'h020, merged}) begin
            $display("FAIL rmw_merge bm=%b: addr=%h data=%h expected 020 %h",
                     bm, mem_wr_addr, mem_wdata, merged);
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, resp_valid} !== 4'b1100) begin
            $display("FAIL rmw_next bm=%b: ready/cs/we/resp=%b expected 1100",
                     bm, {req_ready, mem_cs, mem_we, resp_valid});
            n_fail++;
        end

        tick();
        idle();
        @(negedge clk);
        n_assert++;
        if ({resp_valid, resp_rdata} !== {1'b1, 16'h0000}) begin
            $display("FAIL rmw_ack bm=%b: valid=%b rdata=%h expected 1 0000",
                     bm, resp_valid, resp_rdata);
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if ({resp_valid, resp_rdata} !== {1'b1, merged}) begin
            $display("FAIL rmw_readback bm=%b: valid=%b rdata=%h expected 1 %h",
                     bm, resp_valid, resp_rdata, merged);
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL rmw_tail bm=%b: resp_valid=%b expected 0", bm, resp_valid);
            n_fail++;
        end
    endtask

    task automatic test_noop_write();
        // Address 0x020 holds 0x11EF from the second RMW.
        tick();
        drive(1'b1, 1'b1, 12'h020, 16'hFFFF, 2'b00);
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we} !== 3'b100) begin
            $display("FAIL noop_issue: ready/cs/we=%b expected 100", {req_ready, mem_cs, mem_we});
            n_fail++;
        end

        tick();
        idle();
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, resp_valid} !== 4'b1000) begin
            $display("FAIL noop_gap: ready/cs/we/resp=%b expected 1000",
                     {req_ready, mem_cs, mem_we, resp_valid});
            n_fail++;
        end

        tick();
        drive(1'b1, 1'b0, 12'h020, 16'h0000, 2'b00);
        @(negedge clk);
        n_assert++;
        if ({resp_valid, resp_rdata} !== {1'b1, 16'h0000}) begin
            $display("FAIL noop_ack: valid=%b rdata=%h expected 1 0000", resp_valid, resp_rdata);
            n_fail++;
        end

        tick();
        idle();
        @(negedge clk);
        n_assert++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL noop_gap2: resp_valid=%b expected 0", resp_valid);
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if ({resp_valid, resp_rdata} !== {1'b1, 16'h11EF}) begin
            $display("FAIL noop_unchanged: valid=%b rdata=%h expected 1 11ef",
                     resp_valid, resp_rdata);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_rmw();
        preload(12'h030, 16'h5A5A);

        tick();
        drive(1'b1, 1'b1, 12'h030, 16'h00FF, 2'b01);
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we} !== 3'b110) begin
            $display("FAIL abort_rd: ready/cs/we=%b expected 110", {req_ready, mem_cs, mem_we});
            n_fail++;
        end

        tick();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, resp_valid} !== 4'b0000) begin
            $display("FAIL abort_rst: ready/cs/we/resp=%b expected 0000",
                     {req_ready, mem_cs, mem_we, resp_valid});
            n_fail++;
        end

        // Without the reset the RMW write would issue in this cycle.
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, resp_valid} !== 4'b1000) begin
            $display("FAIL abort_no_wr: ready/cs/we/resp=%b expected 1000",
                     {req_ready, mem_cs, mem_we, resp_valid});
            n_fail++;
        end

        tick();
        drive(1'b1, 1'b0, 12'h030, 16'h0000, 2'b00);
        @(negedge clk);
        n_assert++;
        if ({req_ready, mem_cs, mem_we, resp_valid} !== 4'b1100) begin
            $display("FAIL abort_rd2: ready/cs/we/resp=%b expected 1100",
                     {req_ready, mem_cs, mem_we, resp_valid});
            n_fail++;
        end

        tick();
        idle();
        @(negedge clk);
        n_assert++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL abort_no_ack: resp_valid=%b expected 0", resp_valid);
            n_fail++;
        end

        tick();
        @(negedge clk);
        n_assert++;
        if ({resp_valid, resp_rdata} !== {1'b1, 16'h5A5A}) begin
            $display("FAIL abort_old_data: valid=%b rdata=%h expected 1 5a5a",
                     resp_valid, resp_rdata);
            n_fail++;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_assert = 0;
        n_fail   = 0;
        pre_en   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        rst_n    = 1'b0;
        idle();

        test_reset();
        test_write_read();
        test_back_to_back();
        test_rmw(2'b01, 16'h0055, 16'hBE55);
        test_rmw(2'b10, 16'h1100, 16'h11EF);
        test_noop_write();
        test_reset_mid_rmw();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
